mem_fill_fsm: RTL and testbench

//  Parametrised RAM initialiser. On start, writes every word 0..DEPTH-1 of a

---
 rtl/mem_fill_fsm_if.sv | 27 ++
 rtl/mem_fill_fsm.sv | 202 ++++++++++++++++++++
 tb/tb_mem_fill_fsm.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_fill_fsm_if.sv
// RAM-side bus of the fill/verify engine: address, write data, write enable
// and the synchronous read-data return path.
interface mem_fill_fsm_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_wren;
   logic [DATA_W-1:0] mem_rdata;

   // Fill engine drives the RAM
   modport master (
      output mem_addr,
      output mem_wdata,
      output mem_wren,
      input  mem_rdata
   );

   // RAM side
   modport slave (
      input  mem_addr,
      input  mem_wdata,
      input  mem_wren,
      output mem_rdata
   );
endinterface

// File: rtl/mem_fill_fsm.sv
// Parametrised RAM initialiser: writes words 0..DEPTH-1 with a mode-selected
// pattern, then optionally reads every word back through a READ_LAT-deep
// expected-value pipe and flags the first mismatching address.
module mem_fill_fsm #(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 8,
   parameter int DEPTH    = 2**ADDR_W,
   parameter int READ_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [1:0]        mode,
   input  logic [DATA_W-1:0] fill_val,
   input  logic [DATA_W-1:0] step,
   input  logic              verify_en,
   input  logic              abort,
   mem_fill_fsm_if.master    mem,
   output logic              busy,
   output logic              fin_strobe,
   output logic              err,
   output logic [ADDR_W-1:0] err_addr
);

   // Counter is one bit wider than the address so DEPTH = 2**ADDR_W ends cleanly
   localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(DEPTH - 1);
   localparam int              DRN_W    = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
   localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(READ_LAT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_VFY_ISSUE,
      S_VFY_DRAIN,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic [DRN_W-1:0]  drain_q, drain_d;
   logic [1:0]        mode_q, mode_d;
   logic [DATA_W-1:0] fill_q, fill_d;
   logic [DATA_W-1:0] step_q, step_d;
   logic              verify_q, verify_d;
   logic              err_q, err_d;
   logic [ADDR_W-1:0] err_addr_q, err_addr_d;

   logic [READ_LAT-1:0] vld_q;
   logic [DATA_W-1:0]   exp_q [READ_LAT];
   logic [ADDR_W-1:0]   adr_q [READ_LAT];

   logic              push_vld;
   logic              flush;
   logic [DATA_W-1:0] pat;

   // Pattern for the current address; shared by the write and verify passes
   always_comb begin
      pat = '0;
      unique case (mode_q)
         2'd0:    pat = DATA_W'(cnt_q);
         2'd1:    pat = fill_q;
         2'd2:    pat = acc_q;
         default: pat = DATA_W'(LAST_CNT - cnt_q);
      endcase
   end

   // Next-state, counters, latched run settings and mismatch tracking
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      drain_d    = drain_q;
      mode_d     = mode_q;
      fill_d     = fill_q;
      step_d     = step_q;
      verify_d   = verify_q;
      err_d      = err_q;
      err_addr_d = err_addr_q;
      push_vld   = 1'b0;
      flush      = 1'b0;

      if (vld_q[READ_LAT-1] && (mem.mem_rdata != exp_q[READ_LAT-1])) begin
         err_d = 1'b1;
         if (!err_q) begin
            err_addr_d = adr_q[READ_LAT-1];
         end
      end

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d    = S_WRITE;
               cnt_d      = '0;
               acc_d      = fill_val;
               mode_d     = mode;
               fill_d     = fill_val;
               step_d     = step;
               verify_d   = verify_en;
               err_d      = 1'b0;
               err_addr_d = '0;
            end
         end
         S_WRITE: begin
            cnt_d = cnt_q + 1'b1;
            acc_d = acc_q + step_q;
            if (cnt_q == LAST_CNT) begin
               // Rewind the accumulator so the verify pass regenerates the same sequence
               cnt_d   = '0;
               acc_d   = fill_q;
               state_d = verify_q ? S_VFY_ISSUE : S_DONE;
            end
         end
         S_VFY_ISSUE: begin
            push_vld = 1'b1;
            cnt_d    = cnt_q + 1'b1;
            acc_d    = acc_q + step_q;
            if (cnt_q == LAST_CNT) begin
               cnt_d   = '0;
               drain_d = '0;
               state_d = S_VFY_DRAIN;
            end
         end
         S_VFY_DRAIN: begin
            drain_d = drain_q + 1'b1;
            if (drain_q == DRN_LAST) begin
               state_d = S_DONE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Abort overrides every transition and leaves the error record as it was
      if (abort && (state_q != S_IDLE)) begin
         state_d    = S_IDLE;
         err_d      = err_q;
         err_addr_d = err_addr_q;
         flush      = 1'b1;
      end
   end

   // State, counters and run settings
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         acc_q      <= '0;
         drain_q    <= '0;
         mode_q     <= '0;
         fill_q     <= '0;
         step_q     <= '0;
         verify_q   <= 1'b0;
         err_q      <= 1'b0;
         err_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         drain_q    <= drain_d;
         mode_q     <= mode_d;
         fill_q     <= fill_d;
         step_q     <= step_d;
         verify_q   <= verify_d;
         err_q      <= err_d;
         err_addr_q <= err_addr_d;
      end
   end

   // Expected data, address and valid travel alongside the RAM read latency
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         for (int unsigned i = 0; i < READ_LAT; i++) begin
            exp_q[i] <= '0;
            adr_q[i] <= '0;
         end
      end else begin
         vld_q[0] <= push_vld & ~flush;
         exp_q[0] <= pat;
         adr_q[0] <= cnt_q[ADDR_W-1:0];
         for (int unsigned i = 1; i < READ_LAT; i++) begin
            vld_q[i] <= vld_q[i-1] & ~flush;
            exp_q[i] <= exp_q[i-1];
            adr_q[i] <= adr_q[i-1];
         end
      end
   end

   // Output decode; abort masks the write and the strobe in the same cycle
   always_comb begin
      mem.mem_addr  = cnt_q[ADDR_W-1:0];
      mem.mem_wren  = (state_q == S_WRITE) && !abort;
      mem.mem_wdata = (state_q == S_WRITE) ? pat : '0;
      busy          = (state_q != S_IDLE);
      fin_strobe    = (state_q == S_DONE) && !abort;
      err           = err_q;
      err_addr      = err_addr_q;
   end

endmodule

// File: tb/tb_mem_fill_fsm.sv
// Bench for mem_fill_fsm: two instances (8-bit default and 4-bit/DEPTH 10/
// READ_LAT 3) with behavioural RAMs; a scoreboard queue per instance holds the
// expected completion latency and error record, popped on each fin_strobe.
module tb_mem_fill_fsm;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start8, start4;
   logic [1:0] mode;
   logic [7:0] fill, step;
   logic       verify, abort;
   logic       stuck;

   logic       busy8, fin8, err8;
   logic [7:0] ea8;
   logic       busy4, fin4, err4;
   logic [3:0] ea4;

   logic [7:0] ram8 [256];
   logic [7:0] ram4 [16];
   logic [7:0] rp4  [2];

   int cyc = 0;
   int n_chk = 0;
   int n_pass = 0;
   int sc8 = 0;
   int sc4 = 0;

   typedef struct {
      int         lat;
      bit         err;
      logic [7:0] ea;
   } exp_t;

   exp_t q8[$];
   exp_t q4[$];

   mem_fill_fsm_if #(.ADDR_W(8), .DATA_W(8)) if8 ();
   mem_fill_fsm_if #(.ADDR_W(4), .DATA_W(8)) if4 ();

   mem_fill_fsm #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .READ_LAT(1)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .mode(mode), .fill_val(fill),
      .step(step), .verify_en(verify), .abort(abort), .mem(if8),
      .busy(busy8), .fin_strobe(fin8), .err(err8), .err_addr(ea8)
   );

   mem_fill_fsm #(.ADDR_W(4), .DATA_W(8), .DEPTH(10), .READ_LAT(3)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .mode(mode), .fill_val(fill),
      .step(step), .verify_en(verify), .abort(abort), .mem(if4),
      .busy(busy4), .fin_strobe(fin4), .err(err4), .err_addr(ea4)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // 256x8 RAM, 1-cycle read; optional bit0 stuck-at-1 at 0x10 and 0x20
   always @(posedge clk) begin
      if (if8.mem_wren) begin
         if (stuck && (if8.mem_addr == 8'h10 || if8.mem_addr == 8'h20))
            ram8[if8.mem_addr] <= if8.mem_wdata | 8'h01;
         else
            ram8[if8.mem_addr] <= if8.mem_wdata;
      end
      if8.mem_rdata <= ram8[if8.mem_addr];
   end

   // 16x8 RAM, 3-cycle read; preset to 0xEE during reset to expose stray writes
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) ram4[i] <= 8'hEE;
      end else if (if4.mem_wren) begin
         ram4[if4.mem_addr] <= if4.mem_wdata;
      end
      rp4[0] <= ram4[if4.mem_addr];
      rp4[1] <= rp4[0];
      if4.mem_rdata <= rp4[1];
   end

   task automatic check(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
   endtask

   // Scoreboard monitors: every strobe must match the oldest expectation
   always @(negedge clk) begin
      if (fin8) begin
         if (q8.size() == 0) begin
            check("spurious_strobe8_queue", q8.size(), 1);
         end else begin
            exp_t e;
            e = q8.pop_front();
            check("lat8", cyc - sc8 + 1, e.lat);
            check("err8", int'(err8), int'(e.err));
            check("err_addr8", int'(ea8), int'(e.ea));
         end
      end
   end

   always @(negedge clk) begin
      if (fin4) begin
         if (q4.size() == 0) begin
            check("spurious_strobe4_queue", q4.size(), 1);
         end else begin
            exp_t e;
            e = q4.pop_front();
            check("lat4", cyc - sc4 + 1, e.lat);
            check("err4", int'(err4), int'(e.err));
            check("err_addr4", int'(ea4), {28'd0, ea4} == 32'(e.ea) ? int'(e.ea) : -1);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic go8(input logic [1:0] m, input logic [7:0] f, input logic [7:0] s,
                      input bit v, input bit push, input int lat, input bit e,
                      input logic [7:0] ea);
      exp_t x;
      mode = m; fill = f; step = s; verify = v;
      start8 = 1'b1;
      tick();
      start8 = 1'b0;
      sc8 = cyc;
      x.lat = lat; x.err = e; x.ea = ea;
      if (push) q8.push_back(x);
   endtask

   task automatic wait8(input int bound);
      int n = 0;
      while (q8.size() != 0 && n < bound) begin
         tick();
         n++;
      end
      check("done8_timeout", q8.size(), 0);
      repeat (3) tick();
   endtask

   task automatic check_reset8(input string tag);
      check({tag, "_addr"},     int'(if8.mem_addr),  0);
      check({tag, "_wdata"},    int'(if8.mem_wdata), 0);
      check({tag, "_wren"},     int'(if8.mem_wren),  0);
      check({tag, "_busy"},     int'(busy8),         0);
      check({tag, "_fin"},      int'(fin8),          0);
      check({tag, "_err"},      int'(err8),          0);
      check({tag, "_err_addr"}, int'(ea8),           0);
   endtask

   initial begin
      rst_n = 1'b0; start8 = 1'b0; start4 = 1'b0; mode = 2'd0; fill = 8'h00;
      step = 8'h00; verify = 1'b0; abort = 1'b0; stuck = 1'b0;
      #12;
      check_reset8("reset");
      tick(); tick();
      rst_n = 1'b1;
      tick();

      // 1: identity fill, no verify
      go8(2'd0, 8'h00, 8'h00, 1'b0, 1'b1, 257, 1'b0, 8'h00);
      check("busy_running", int'(busy8), 1);
      wait8(600);
      check("t1_ram00", int'(ram8[8'h00]), 8'h00);
      check("t1_ram7f", int'(ram8[8'h7F]), 8'h7F);
      check("t1_ram80", int'(ram8[8'h80]), 8'h80);
      check("t1_ramff", int'(ram8[8'hFF]), 8'hFF);

      // 2: arithmetic 5 + 3a with verify; inputs and start toggle mid-run
      go8(2'd2, 8'h05, 8'h03, 1'b1, 1'b1, 514, 1'b0, 8'h00);
      repeat (20) tick();
      mode = 2'd1; fill = 8'hFF; step = 8'h11; verify = 1'b0;
      start8 = 1'b1;
      tick();
      start8 = 1'b0;
      wait8(1200);
      check("t2_ram00", int'(ram8[8'h00]), 8'h05);
      check("t2_ram01", int'(ram8[8'h01]), 8'h08);
      check("t2_ram02", int'(ram8[8'h02]), 8'h0B);
      check("t2_ramff", int'(ram8[8'hFF]), 8'h02);

      // 3: constant 0 with stuck bits; first failing address kept
      stuck = 1'b1;
      go8(2'd1, 8'h00, 8'h00, 1'b1, 1'b1, 514, 1'b1, 8'h10);
      wait8(1200);
      check("t3_err_hold", int'(err8), 1);
      check("t3_err_addr_hold", int'(ea8), 8'h10);

      // 4: abort at address 0x40, then a clean refill clears err
      stuck = 1'b0;
      go8(2'd0, 8'h00, 8'h00, 1'b0, 1'b0, 0, 1'b0, 8'h00);
      begin
         int n = 0;
         while (!(if8.mem_addr == 8'h40 && if8.mem_wren) && n < 400) begin
            tick();
            n++;
         end
         check("t4_reach_40_timeout", int'(n < 400), 1);
      end
      abort = 1'b1;
      #1;
      check("t4_wren_abort_cycle", int'(if8.mem_wren), 0);
      tick();
      abort = 1'b0;
      check("t4_busy_after_abort", int'(busy8), 0);
      check("t4_wren_after_abort", int'(if8.mem_wren), 0);
      repeat (300) tick();
      check("t4_ram3f", int'(ram8[8'h3F]), 8'h3F);
      check("t4_ram20", int'(ram8[8'h20]), 8'h20);
      check("t4_ram41", int'(ram8[8'h41]), 8'h00);
      check("t4_ram80", int'(ram8[8'h80]), 8'h00);
      check("t4_ramff", int'(ram8[8'hFF]), 8'h00);
      go8(2'd0, 8'h00, 8'h00, 1'b0, 1'b1, 257, 1'b0, 8'h00);
      wait8(600);
      begin
         int bad = 0;
         for (int i = 0; i < 256; i++) if (ram8[i] != 8'(i)) bad++;
         check("t4_refill_all", bad, 0);
      end

      // 5: async reset in the middle of verify issue; no strobe afterwards
      stuck = 1'b1;
      go8(2'd1, 8'h00, 8'h00, 1'b1, 1'b1, 514, 1'b1, 8'h10);
      repeat (256 + 8'h30) tick();
      check("t5_busy_pre", int'(busy8), 1);
      check("t5_err_pre", int'(err8), 1);
      check("t5_addr_pre", int'(if8.mem_addr), 8'h30);
      rst_n = 1'b0;
      #1;
      check_reset8("t5_async");
      q8.delete();
      tick();
      rst_n = 1'b1;
      repeat (600) tick();
      check("t5_idle_after", int'(busy8), 0);
      stuck = 1'b0;

      // 6: small instance, descending, DEPTH 10, READ_LAT 3
      mode = 2'd3; fill = 8'h00; step = 8'h00; verify = 1'b1;
      start4 = 1'b1;
      tick();
      start4 = 1'b0;
      sc4 = cyc;
      begin
         exp_t x;
         int n = 0;
         x.lat = 24; x.err = 1'b0; x.ea = 8'h00;
         q4.push_back(x);
         while (q4.size() != 0 && n < 100) begin
            tick();
            n++;
         end
         check("done4_timeout", q4.size(), 0);
      end
      repeat (3) tick();
      check("t6_ram0", int'(ram4[0]), 9);
      check("t6_ram4", int'(ram4[4]), 5);
      check("t6_ram9", int'(ram4[9]), 0);
      check("t6_ram10", int'(ram4[10]), 8'hEE);
      check("t6_ram15", int'(ram4[15]), 8'hEE);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
